mux_scan_seq: RTL and testbench
===============================

# mux_scan_seq

Scan sequencer that drives the 6-bit `addr` input of the analog-mux select decoder (the F1/F2/F3 8:1 select generator) and collects one ADC sample per address. It steps `addr` through every measurement address, waits a programmable settling time after each change, runs an ADC request/acknowledge handshake, and sums each group of consecutive samples into one per-test-point result. When the scan ends it parks the mux on the all-zero select address.

## Interface
Parameters:
- `ADC_W`, 12: ADC sample width.
- `GROUP_SIZE`, 5: consecutive addresses per test point.
- `NUM_POINTS`, 6: test points per scan; last scanned address = `GROUP_SIZE*NUM_POINTS-1` (29).
- `PARK_ADDR`, 30: address driven when idle (all select lines 0).
- `SETTLE_CYCLES`, 1000: settle wait after each `addr` change, at least 1.
- `ACK_TIMEOUT`, 4096: maximum cycles `adc_req` may stay high without `adc_ack`.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  one-cycle scan request.
- `abort`  in  1  one-cycle scan cancel.
- `addr`  out  6  mux address to the select decoder.
- `adc_req`  out  1  conversion request, level.
- `adc_ack`  in  1  one-cycle pulse; `adc_data` is valid with it.
- `adc_data`  in  ADC_W  conversion result.
- `pt_valid`  out  1  one-cycle result strobe.
- `pt_index`  out  3  test-point index, 0..NUM_POINTS-1.
- `pt_sum`  out  ADC_W+3  sum of GROUP_SIZE samples (15 bits by default).
- `busy`  out  1  scan in progress.
- `done`  out  1  one-cycle pulse on normal scan completion.
- `err`  out  1  sticky ACK timeout flag; cleared by the next accepted `start`.

## Operation
- States:
  - IDLE: `addr`=PARK_ADDR, `busy`=0.
  - SETTLE: count down the settle time.
  - CONV: `adc_req`=1, wait for `adc_ack`.
  - NEXT: accumulate the sample and advance the address.
  - IDLE is re-entered after the last address.
- IDLE + `start` → SETTLE. In the same transition: `addr`←0, accumulator←0, group counter←0, point counter←0, `err`←0.
- SETTLE → CONV when the settle counter expires.
- CONV + `adc_ack` → NEXT. `adc_data` is zero-extended and added into the accumulator.
- NEXT:
  - If the group counter equals GROUP_SIZE-1: pulse `pt_valid`, set `pt_sum` to the accumulator and `pt_index` to the point counter, then clear the accumulator and group counter.
  - If the address was the last one: `addr`←PARK_ADDR, pulse `done`, go to IDLE.
  - Otherwise: `addr`←`addr`+1, reload the settle counter, go to SETTLE.
- ACK timeout: `adc_req` high for ACK_TIMEOUT cycles without `adc_ack` sets `err`, drops `adc_req`, parks `addr`, and returns to IDLE. No `done` is issued.
- `abort` in any non-IDLE state has the same effect as a timeout except that `err` is left unchanged. No partial `pt_valid` is issued.
- `start` while `busy` is ignored. If `start` and `abort` arrive in the same cycle, `abort` wins (in IDLE both are no-ops).
- `adc_ack` outside CONV is ignored.
- Arithmetic: the accumulator is ADC_W+3 bits and cannot overflow for GROUP_SIZE ≤ 8. Counters do not wrap; the end is detected by compare.

## Timing
- Reset values:
  - `addr`=PARK_ADDR.
  - `adc_req`=0, `pt_valid`=0, `pt_index`=0, `pt_sum`=0.
  - `busy`=0, `done`=0, `err`=0.
  - State = IDLE.
- Reset mid-scan: all of the above take effect at the next edge; an in-flight ADC conversion is abandoned.
- All outputs are registered.
- `start` sampled at edge t: `addr`=0 and `busy`=1 from t+1.
- `adc_req` rises SETTLE_CYCLES+1 cycles after each `addr` change. The extra cycle covers the decoder's register stage.
- `adc_ack` at edge a:
  - `adc_req` falls at a+1.
  - The next `addr` (or PARK_ADDR) appears at a+2.
  - `pt_valid` and `done` pulse at a+2.
- `busy` falls together with `done`.
- `adc_req` holds until ack, timeout, or abort, and never re-asserts without a new settle period.

## Structure
- Package `mux_scan_pkg`: state enum (IDLE, SETTLE, CONV, NEXT), PARK_ADDR default, and the address-width and sum-width constants.
- One sub-module, `scan_timer`: a loadable down-counter with an expiry flag, instantiated twice (settle and ACK timeout).

## Test plan
- Normal scan (SETTLE_CYCLES=4, ADC model acks 3 cycles after `adc_req` with `adc_data`=`addr`*10) → 30 requests and 6 `pt_valid` pulses:
  - point 0 sum = 100;
  - point 1 sum = 350;
  - point 5 sum = 1350.
  - One `done`, then `addr`=30.
- Settle check → every `adc_req` rise occurs exactly 5 cycles after its `addr` change; `addr` never changes while `adc_req`=1.
- ADC never acks at address 7 (ACK_TIMEOUT=16) → `err`=1, `adc_req` low after 16 cycles, `addr`=30, point 0 reported, no `done`. The next `start` clears `err`.
- `abort` pulsed during CONV at address 12 → next cycle `busy`=0 and `addr`=30, no `pt_valid` for point 2, `err` unchanged. `start` and `abort` in the same cycle while idle → stays idle.
- `start` pulsed again while busy, plus a stray `adc_ack` during SETTLE → ignored; results are identical to the normal-scan scenario.
- `rst_n` low for 1 cycle during CONV at address 18 → all outputs at their reset values; a fresh scan afterwards gives correct sums.

Source files
------------

// File: rtl/mux_scan_seq_pkg.sv
// mux_scan_seq shared types and constants.
// State encoding, address/sum widths and park address.
package mux_scan_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CONV,
    S_NEXT
  } state_e;

  localparam int ADDR_W = 6;
  localparam int IDX_W  = 3;
  localparam int SUM_X  = 3;

  localparam logic [ADDR_W-1:0] PARK_DEF = 6'd30;

  function automatic int sum_w(input int adc_w);
    return adc_w + SUM_X;
  endfunction

endpackage

// File: rtl/mux_scan_seq_if.sv
// mux_scan_seq control, ADC handshake and result bus.
// master = sequencer side, slave = system/ADC side.
interface mux_scan_seq_if #(
  parameter int ADC_W = 12
) ();
  import mux_scan_pkg::*;

  logic                     start;
  logic                     abort;
  logic [ADDR_W-1:0]        addr;
  logic                     adc_req;
  logic                     adc_ack;
  logic [ADC_W-1:0]         adc_data;
  logic                     pt_valid;
  logic [IDX_W-1:0]         pt_index;
  logic [sum_w(ADC_W)-1:0]  pt_sum;
  logic                     busy;
  logic                     done;
  logic                     err;

  modport master (
    input  start, abort, adc_ack, adc_data,
    output addr, adc_req, pt_valid, pt_index,
    output pt_sum, busy, done, err
  );

  modport slave (
    output start, abort, adc_ack, adc_data,
    input  addr, adc_req, pt_valid, pt_index,
    input  pt_sum, busy, done, err
  );

endinterface

// File: rtl/mux_scan_seq_scan_timer.sv
// Loadable down-counter with expiry flag.
// Holds at zero; expired while the count is zero.
module scan_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  output logic         exp_o
);

  logic [W-1:0] cnt_q;

  // Reload while held, otherwise count down to zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign exp_o = (cnt_q == '0);

endmodule

// File: rtl/mux_scan_seq.sv
// Analog-mux scan sequencer: settle, ADC handshake,
// per-point group sums, park on idle.
module mux_scan_seq
  import mux_scan_pkg::*;
#(
  parameter int ADC_W         = 12,
  parameter int GROUP_SIZE    = 5,
  parameter int NUM_POINTS    = 6,
  parameter logic [ADDR_W-1:0] PARK_ADDR = PARK_DEF,
  parameter int SETTLE_CYCLES = 1000,
  parameter int ACK_TIMEOUT   = 4096
) (
  input logic            clk,
  input logic            rst_n,
  mux_scan_seq_if.master bus
);

  localparam int SW   = sum_w(ADC_W);
  localparam int GW   = $clog2(GROUP_SIZE + 1);
  localparam int TMAX = (SETTLE_CYCLES > ACK_TIMEOUT) ?
                        SETTLE_CYCLES : ACK_TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(GROUP_SIZE * NUM_POINTS - 1);
  localparam logic [GW-1:0] GLAST = GW'(GROUP_SIZE - 1);

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic              req_q;
  logic              pv_q;
  logic [IDX_W-1:0]  pidx_q;
  logic [SW-1:0]     psum_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic [SW-1:0]     acc_q;
  logic [SW-1:0]     acc_d;
  logic [GW-1:0]     grp_q;
  logic [IDX_W-1:0]  pt_q;
  logic              set_exp;
  logic              ack_exp;

  assign acc_d = acc_q + SW'(bus.adc_data);

  scan_timer #(.W(TW)) u_settle (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (state_q != S_SETTLE),
    .val_i  (TW'(SETTLE_CYCLES)),
    .exp_o  (set_exp)
  );

  scan_timer #(.W(TW)) u_ack (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (state_q != S_CONV),
    .val_i  (TW'(ACK_TIMEOUT - 1)),
    .exp_o  (ack_exp)
  );

  // Scan FSM with registered outputs; abort beats everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= PARK_ADDR;
      req_q   <= 1'b0;
      pv_q    <= 1'b0;
      pidx_q  <= '0;
      psum_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      acc_q   <= '0;
      grp_q   <= '0;
      pt_q    <= '0;
    end else begin
      pv_q   <= 1'b0;
      done_q <= 1'b0;
      if (bus.abort && state_q != S_IDLE) begin
        state_q <= S_IDLE;
        addr_q  <= PARK_ADDR;
        req_q   <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (bus.start && !bus.abort) begin
              state_q <= S_SETTLE;
              addr_q  <= '0;
              acc_q   <= '0;
              grp_q   <= '0;
              pt_q    <= '0;
              err_q   <= 1'b0;
              busy_q  <= 1'b1;
            end
          end
          S_SETTLE: begin
            if (set_exp) begin
              state_q <= S_CONV;
              req_q   <= 1'b1;
            end
          end
          S_CONV: begin
            if (bus.adc_ack) begin
              state_q <= S_NEXT;
              req_q   <= 1'b0;
              acc_q   <= acc_d;
            end else if (ack_exp) begin
              state_q <= S_IDLE;
              req_q   <= 1'b0;
              err_q   <= 1'b1;
              addr_q  <= PARK_ADDR;
              busy_q  <= 1'b0;
            end
          end
          S_NEXT: begin
            if (grp_q == GLAST) begin
              pv_q   <= 1'b1;
              psum_q <= acc_q;
              pidx_q <= pt_q;
              acc_q  <= '0;
              grp_q  <= '0;
              pt_q   <= pt_q + IDX_W'(1);
            end else begin
              grp_q  <= grp_q + GW'(1);
            end
            if (addr_q == LAST) begin
              state_q <= S_IDLE;
              addr_q  <= PARK_ADDR;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q <= S_SETTLE;
              addr_q  <= addr_q + ADDR_W'(1);
            end
          end
        endcase
      end
    end
  end

  assign bus.addr     = addr_q;
  assign bus.adc_req  = req_q;
  assign bus.pt_valid = pv_q;
  assign bus.pt_index = pidx_q;
  assign bus.pt_sum   = psum_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_mux_scan_seq.sv
// Scoreboard bench for mux_scan_seq.
// Reference sums come from a per-address data table.
module tb_mux_scan_seq;

  localparam int SETTLE = 4;
  localparam int TMO    = 16;
  localparam int GS     = 5;
  localparam int NP     = 6;
  localparam int NA     = GS * NP;
  localparam int PARK   = 30;

  typedef struct {
    bit is_done;
    int idx;
    int sum;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mux_scan_seq_if #(.ADC_W(12)) bus ();

  mux_scan_seq #(
    .SETTLE_CYCLES (SETTLE),
    .ACK_TIMEOUT   (TMO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   n_chk = 0;
  int   n_err = 0;
  exp_t exp_q[$];
  int   data_tbl[NA];
  int   ack_dly = 3;
  int   noack = -1;
  bit   stray = 1'b0;
  int   got_sum[8];
  int   n_pv = 0;
  int   n_done = 0;
  int   n_rise = 0;
  int   n_viol = 0;
  int   len = 0;
  int   last_len = 0;
  int   rcnt = 0;
  int   cyc = 0;
  int   chg_cyc = 0;
  logic [5:0] prev_addr = '0;
  logic prev_req = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  // Monitor: scoreboard pops and settle/hold tracking.
  always @(negedge clk) begin
    exp_t e;
    if (bus.pt_valid === 1'b1) begin
      n_pv++;
      got_sum[bus.pt_index] = 32'(bus.pt_sum);
      if (exp_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL extra_pt_valid: got index %0d expected none",
                 bus.pt_index);
      end else begin
        e = exp_q.pop_front();
        check("pt_kind", 32'(e.is_done), 32'(0));
        check("pt_index", 32'(bus.pt_index), e.idx);
        check("pt_sum", 32'(bus.pt_sum), e.sum);
      end
    end
    if (bus.done === 1'b1) begin
      n_done++;
      if (exp_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL extra_done: got done expected none");
      end else begin
        e = exp_q.pop_front();
        check("done_kind", 32'(e.is_done), 32'(1));
      end
    end
    if (bus.addr !== prev_addr) begin
      if (prev_req === 1'b1 && bus.adc_req === 1'b1)
        n_viol++;
      chg_cyc = cyc;
    end
    if (bus.adc_req === 1'b1 && prev_req !== 1'b1) begin
      n_rise++;
      check("settle_gap", cyc - chg_cyc, SETTLE + 1);
      len = 1;
    end else if (bus.adc_req === 1'b1) begin
      len++;
    end else if (prev_req === 1'b1) begin
      last_len = len;
    end
    prev_addr = bus.addr;
    prev_req  = bus.adc_req;
  end

  // ADC model: ack ack_dly cycles after req rises.
  initial begin
    bus.adc_ack  = 1'b0;
    bus.adc_data = '0;
    forever begin
      @(negedge clk);
      bus.adc_ack = 1'b0;
      if (bus.adc_req === 1'b1) begin
        rcnt++;
        if (rcnt == ack_dly && int'(bus.addr) != noack) begin
          bus.adc_ack  = 1'b1;
          bus.adc_data = 12'(data_tbl[bus.addr]);
        end
      end else begin
        rcnt = 0;
        if (stray) begin
          bus.adc_ack  = 1'b1;
          bus.adc_data = 12'hFFF;
          stray = 1'b0;
        end
      end
    end
  end

  task automatic fill(input bit ramp);
    for (int a = 0; a < NA; a++)
      data_tbl[a] = ramp ? a * 10 : int'($urandom_range(0, 4095));
  endtask

  // Points whose five samples all precede address cut.
  task automatic push_expect(input int cut);
    exp_t e;
    for (int p = 0; p < NP; p++) begin
      if (p * GS + GS - 1 < cut) begin
        e.is_done = 1'b0;
        e.idx = p;
        e.sum = 0;
        for (int k = 0; k < GS; k++)
          e.sum += data_tbl[p * GS + k];
        exp_q.push_back(e);
      end
    end
    if (cut >= NA) begin
      e.is_done = 1'b1;
      e.idx = 0;
      e.sum = 0;
      exp_q.push_back(e);
    end
  endtask

  task automatic clr_counts();
    n_pv = 0;
    n_done = 0;
    n_rise = 0;
    for (int i = 0; i < 8; i++) got_sum[i] = -1;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (bus.busy === 1'b0) break;
    end
    check(nm, 32'(bus.busy), 32'(0));
    @(negedge clk);
  endtask

  task automatic wait_req_at(input int a);
    for (int i = 0; i < 3000; i++) begin
      if (bus.adc_req === 1'b1 && int'(bus.addr) == a) break;
      @(negedge clk);
    end
    check("reach_addr", {25'd0, bus.adc_req, bus.addr},
          {25'd0, 1'b1, 6'(a)});
  endtask

  task automatic check_reset_vals(input string nm);
    check({nm, "_addr"}, 32'(bus.addr), PARK);
    check({nm, "_req"}, 32'(bus.adc_req), 0);
    check({nm, "_pv"}, 32'(bus.pt_valid), 0);
    check({nm, "_pidx"}, 32'(bus.pt_index), 0);
    check({nm, "_psum"}, 32'(bus.pt_sum), 0);
    check({nm, "_busy"}, 32'(bus.busy), 0);
    check({nm, "_done"}, 32'(bus.done), 0);
    check({nm, "_err"}, 32'(bus.err), 0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    fill(1'b1);
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    rst_n = 1'b1;

    // Normal ramp scan.
    clr_counts();
    ack_dly = 3;
    push_expect(NA);
    pulse_start();
    check("start_busy", 32'(bus.busy), 1);
    check("start_addr", 32'(bus.addr), 0);
    wait_idle("normal_end");
    check("norm_reqs", n_rise, 30);
    check("norm_pv", n_pv, 6);
    check("norm_done", n_done, 1);
    check("norm_park", 32'(bus.addr), PARK);
    check("norm_err", 32'(bus.err), 0);
    check("norm_q", exp_q.size(), 0);
    check("norm_p0", got_sum[0], 100);
    check("norm_p1", got_sum[1], 350);
    check("norm_p5", got_sum[5], 1350);

    // ACK timeout at address 7.
    clr_counts();
    fill(1'b0);
    noack = 7;
    ack_dly = int'($urandom_range(1, 4));
    push_expect(7);
    pulse_start();
    wait_idle("tmo_end");
    check("tmo_err", 32'(bus.err), 1);
    check("tmo_park", 32'(bus.addr), PARK);
    check("tmo_req", 32'(bus.adc_req), 0);
    check("tmo_len", last_len, TMO);
    check("tmo_done", n_done, 0);
    check("tmo_pv", n_pv, 1);
    check("tmo_q", exp_q.size(), 0);
    noack = -1;

    // Abort during CONV at address 12.
    clr_counts();
    fill(1'b0);
    ack_dly = int'($urandom_range(2, 4));
    push_expect(12);
    pulse_start();
    check("err_cleared", 32'(bus.err), 0);
    wait_req_at(12);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abt_busy", 32'(bus.busy), 0);
    check("abt_park", 32'(bus.addr), PARK);
    check("abt_req", 32'(bus.adc_req), 0);
    check("abt_err", 32'(bus.err), 0);
    repeat (3) @(negedge clk);
    check("abt_q", exp_q.size(), 0);
    check("abt_pv", n_pv, 2);
    check("abt_done", n_done, 0);

    // start with abort while idle.
    @(negedge clk);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("sa_busy", 32'(bus.busy), 0);
    check("sa_addr", 32'(bus.addr), PARK);
    repeat (3) @(negedge clk);
    check("sa_hold", 32'(bus.busy), 0);

    // Repeated start and stray ack are ignored.
    clr_counts();
    fill(1'b1);
    ack_dly = 3;
    push_expect(NA);
    pulse_start();
    repeat (20) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (int'(bus.addr) == 3) break;
      @(negedge clk);
    end
    stray = 1'b1;
    wait_idle("ign_end");
    check("ign_reqs", n_rise, 30);
    check("ign_pv", n_pv, 6);
    check("ign_done", n_done, 1);
    check("ign_q", exp_q.size(), 0);
    check("ign_p0", got_sum[0], 100);
    check("ign_p5", got_sum[5], 1350);

    // Reset during CONV at address 18.
    clr_counts();
    fill(1'b0);
    ack_dly = int'($urandom_range(1, 5));
    push_expect(18);
    pulse_start();
    wait_req_at(18);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_reset_vals("mid_rst");
    repeat (2) @(negedge clk);
    check("mrst_q", exp_q.size(), 0);
    check("mrst_pv", n_pv, 3);

    // Fresh random scans.
    for (int k = 0; k < 2; k++) begin
      clr_counts();
      fill(1'b0);
      ack_dly = int'($urandom_range(1, 5));
      push_expect(NA);
      pulse_start();
      wait_idle("rnd_end");
      check("rnd_q", exp_q.size(), 0);
      check("rnd_done", n_done, 1);
      check("rnd_pv", n_pv, 6);
    end

    check("addr_chg_under_req", n_viol, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
